// File: rtl/coh_acc_mbin.sv
// coh_acc_mbin: rotates each accepted correlation by FREQ_NUM per-bin twiddles and
// read-modify-writes the coherent RAM word. Define COH_ACC_SAT_CNT_EN to add sat_count.
module coh_acc_mbin #(
  parameter int COH_DATA_NUMBER = 682,
  parameter int FREQ_NUM        = 8,
  parameter int IN_WIDTH        = 16,
  parameter int ACC_WIDTH       = 24,
  parameter int TW_WIDTH        = 10,
  localparam int IDX_W  = (FREQ_NUM > 1) ? $clog2(FREQ_NUM) : 1,
  localparam int EXP_W  = $clog2(ACC_WIDTH) + 1,
  localparam int ADDR_W = $clog2(COH_DATA_NUMBER + 1),
  localparam int WORD_W = 2 * ACC_WIDTH * FREQ_NUM
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [IN_WIDTH-1:0] cor_result_i,
  input  logic [IN_WIDTH-1:0] cor_result_q,
  input  logic                cor_result_valid,
  output logic                cor_result_ready,
  input  logic                first_result,
  input  logic                first_segment,
  input  logic                first_acc,
  output logic [IDX_W-1:0]    twiddle_index,
  input  logic [TW_WIDTH-1:0] twiddle_cos,
  input  logic [TW_WIDTH-1:0] twiddle_sin,
  output logic                read_finish,
  output logic                write_finish,
  output logic [EXP_W-1:0]    max_exp,
  output logic                rd,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [WORD_W-1:0]   d4wt,
  input  logic [WORD_W-1:0]   d4rd
`ifdef COH_ACC_SAT_CNT_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  localparam int MUL_W = IN_WIDTH + TW_WIDTH + 1;
  localparam int P_W   = IN_WIDTH + 2;
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic [ADDR_W-1:0]          ADDR_END = ADDR_W'(COH_DATA_NUMBER);
  localparam logic [IDX_W-1:0]           BIN_LAST = IDX_W'(FREQ_NUM - 1);
  localparam logic signed [MUL_W-1:0]    RND      = MUL_W'(1 << (TW_WIDTH - 2));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE} state_t;

  function automatic logic signed [P_W-1:0] round_tw(input logic signed [MUL_W-1:0] v);
    logic signed [MUL_W-1:0] r;
    r = v + RND;
    return P_W'(r >>> (TW_WIDTH - 1));
  endfunction

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] != v[SUM_W-2];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (!sat_hit(v)) return v[ACC_WIDTH-1:0];
    return v[SUM_W-1] ? ACC_MIN : ACC_MAX;
  endfunction

  function automatic logic [EXP_W-1:0] bit_cnt(input logic [ACC_WIDTH-1:0] v);
    logic [EXP_W-1:0] n;
    n = '0;
    for (int k = 0; k < ACC_WIDTH - 1; k++)
      if (v[k] != v[ACC_WIDTH-1]) n = EXP_W'(k + 1);
    return n;
  endfunction

  function automatic logic [EXP_W-1:0] exp_max(input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                  state, state_nxt;
  logic                    accept, bin_last;
  logic [IDX_W-1:0]        bin_idx;
  logic [ADDR_W-1:0]       rd_addr, wr_addr;
  logic signed [IN_WIDTH-1:0] x_p0, y_p0;
  logic                    first_seg_p0, first_acc_p0;
  logic [WORD_W-1:0]       word_p1;
  logic [EXP_W-1:0]        txn_exp, bin_exp;
  logic signed [TW_WIDTH-1:0]  tw_c, tw_s;
  logic signed [ACC_WIDTH-1:0] ram_i, ram_q, new_i, new_q;
  logic signed [MUL_W-1:0] mul_i, mul_q;
  logic signed [P_W-1:0]   p_i, p_q;
  logic signed [SUM_W-1:0] sum_i, sum_q;
  int                      base;

  assign accept           = cor_result_valid & cor_result_ready;
  assign bin_last         = (bin_idx == BIN_LAST);
  assign cor_result_ready = (state == S_IDLE);
  assign rd               = (state == S_READ);
  assign we               = (state == S_WRITE);
  assign addr             = rd ? rd_addr : (we ? wr_addr : '0);
  assign twiddle_index    = bin_idx;
  assign read_finish      = (rd_addr == ADDR_END);
  assign write_finish     = (wr_addr == ADDR_END);
  assign d4wt             = word_p1;
  assign tw_c             = twiddle_cos;
  assign tw_s             = twiddle_sin;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cor_result_valid) state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CALC;
      S_CALC:  if (bin_last) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // stage p1 -> p2: one bin rotated, accumulated and saturated per CALC cycle
  always_comb begin
    base  = int'(bin_idx) * 2 * ACC_WIDTH;
    ram_i = word_p1[base + ACC_WIDTH +: ACC_WIDTH];
    ram_q = word_p1[base +: ACC_WIDTH];
    mul_i = MUL_W'(x_p0) * MUL_W'(tw_c) - MUL_W'(y_p0) * MUL_W'(tw_s);
    mul_q = MUL_W'(x_p0) * MUL_W'(tw_s) + MUL_W'(y_p0) * MUL_W'(tw_c);
    if (first_acc_p0) begin
      p_i = P_W'(x_p0);
      p_q = P_W'(y_p0);
    end else begin
      p_i = round_tw(mul_i);
      p_q = round_tw(mul_q);
    end
    sum_i   = first_seg_p0 ? SUM_W'(p_i) : (SUM_W'(ram_i) + SUM_W'(p_i));
    sum_q   = first_seg_p0 ? SUM_W'(p_q) : (SUM_W'(ram_q) + SUM_W'(p_q));
    new_i   = sat_acc(sum_i);
    new_q   = sat_acc(sum_q);
    bin_exp = exp_max(bit_cnt(new_i), bit_cnt(new_q));
  end

  // stage p0: input sample captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0 <= cor_result_i;
      y_p0 <= cor_result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= S_IDLE;
      bin_idx      <= '0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      max_exp      <= '0;
      txn_exp      <= '0;
      first_seg_p0 <= 1'b0;
      first_acc_p0 <= 1'b0;
      word_p1      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          first_seg_p0 <= first_segment;
          first_acc_p0 <= first_acc;
          if (first_result || rd_addr == ADDR_END) rd_addr <= '0;
          if (first_result || wr_addr == ADDR_END) wr_addr <= '0;
          if (first_result && first_acc) max_exp <= '0;
        end
        S_READ: if (rd_addr != ADDR_END) rd_addr <= rd_addr + ADDR_W'(1);
        S_WAIT: begin
          word_p1 <= d4rd;
          txn_exp <= '0;
        end
        S_CALC: begin
          word_p1[base +: 2*ACC_WIDTH] <= {new_i, new_q};
          txn_exp <= exp_max(txn_exp, bin_exp);
          bin_idx <= bin_last ? '0 : bin_idx + IDX_W'(1);
        end
        S_WRITE: begin
          if (wr_addr != ADDR_END) wr_addr <= wr_addr + ADDR_W'(1);
          max_exp <= exp_max(max_exp, txn_exp);
        end
        default: ;
      endcase
    end
  end

`ifdef COH_ACC_SAT_CNT_EN
  logic [15:0] txn_sat;
  logic [1:0]  bin_sat;
  logic [16:0] sat_sum;

  assign bin_sat = 2'(sat_hit(sum_i)) + 2'(sat_hit(sum_q));
  assign sat_sum = 17'(sat_count) + 17'(txn_sat);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sat_count <= '0;
      txn_sat   <= '0;
    end else begin
      if (accept && first_result && first_acc) sat_count <= '0;
      else if (state == S_WRITE) sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      if (state == S_WAIT) txn_sat <= '0;
      else if (state == S_CALC) txn_sat <= txn_sat + 16'(bin_sat);
    end
  end
`endif

endmodule

// File: tb/tb_coh_acc_mbin.sv
// Directed bench for coh_acc_mbin with FREQ_NUM=4 and a behavioural one-cycle-latency RAM.
module tb_coh_acc_mbin;

  localparam int AW = 24;
  localparam int FN = 4;
  localparam int WW = 2 * AW * FN;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [15:0]   cor_result_i, cor_result_q;
  logic          cor_result_valid, cor_result_ready;
  logic          first_result, first_segment, first_acc;
  logic [1:0]    twiddle_index;
  logic [9:0]    twiddle_cos, twiddle_sin;
  logic          read_finish, write_finish;
  logic [5:0]    max_exp;
  logic          rd, we;
  logic [9:0]    addr;
  logic [WW-1:0] d4wt, d4rd;
`ifdef COH_ACC_SAT_CNT_EN
  logic [15:0]   sat_count;
`endif

  logic [9:0]    tw_cos_tab [4];
  logic [9:0]    tw_sin_tab [4];
  logic [WW-1:0] mem [0:682];
  logic          poke_en;
  logic [9:0]    poke_addr;
  logic [WW-1:0] poke_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign twiddle_cos = tw_cos_tab[twiddle_index];
  assign twiddle_sin = tw_sin_tab[twiddle_index];

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (we) mem[addr] <= d4wt;
    if (rd) d4rd <= mem[addr];
  end

  coh_acc_mbin #(
    .COH_DATA_NUMBER(682), .FREQ_NUM(FN), .IN_WIDTH(16), .ACC_WIDTH(AW), .TW_WIDTH(10)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .cor_result_i(cor_result_i), .cor_result_q(cor_result_q),
    .cor_result_valid(cor_result_valid), .cor_result_ready(cor_result_ready),
    .first_result(first_result), .first_segment(first_segment), .first_acc(first_acc),
    .twiddle_index(twiddle_index), .twiddle_cos(twiddle_cos), .twiddle_sin(twiddle_sin),
    .read_finish(read_finish), .write_finish(write_finish), .max_exp(max_exp),
    .rd(rd), .we(we), .addr(addr), .d4wt(d4wt), .d4rd(d4rd)
`ifdef COH_ACC_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  function automatic logic signed [AW-1:0] get_i(input logic [WW-1:0] w, input int k);
    return w[(2*k+1)*AW +: AW];
  endfunction

  function automatic logic signed [AW-1:0] get_q(input logic [WW-1:0] w, input int k);
    return w[(2*k)*AW +: AW];
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [WW-1:0] w);
    @(negedge clk);
    poke_addr = a;
    poke_data = w;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // returns at the negedge of the READ cycle
  task automatic send(input int xi, input int xq, input logic fr, input logic fs, input logic fa);
    int n;
    n = 0;
    @(negedge clk);
    while (!cor_result_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", cor_result_ready, 1);
    cor_result_valid = 1'b1;
    cor_result_i     = 16'(xi);
    cor_result_q     = 16'(xq);
    first_result     = fr;
    first_segment    = fs;
    first_acc        = fa;
    @(negedge clk);
    cor_result_valid = 1'b0;
  endtask

  task automatic wait_we(output int n, output logic rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    while (!we && n < 20) begin
      @(negedge clk);
      n++;
      if (cor_result_ready) rdy_seen = 1'b1;
    end
    check("we_seen", we, 1);
  endtask

  initial begin
    int            n, acc_n, wr_n, last;
    logic          rdy_seen, bad;
    logic [WW-1:0] w;
    int            seq_x [3];

    seq_x = '{11, 22, 33};
    tw_cos_tab = '{10'd511, 10'd0, 10'd511, 10'd511};
    tw_sin_tab = '{10'd0, 10'd511, 10'd0, 10'd0};
    rst_b = 1'b0;
    cor_result_valid = 1'b0;
    cor_result_i = '0;
    cor_result_q = '0;
    first_result = 1'b0;
    first_segment = 1'b0;
    first_acc = 1'b0;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_data = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", cor_result_ready, 1);
    check("rst_rd", rd, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_max_exp", max_exp, 0);
    check("rst_rfin", read_finish, 0);
    check("rst_wfin", write_finish, 0);
    check("rst_d4wt", d4wt[63:0], 0);
    rst_b = 1'b1;

    // first accumulation: all bins take the input unchanged
    send(100, -50, 1'b1, 1'b1, 1'b1);
    check("t1_rd", rd, 1);
    check("t1_rd_addr", addr, 0);
    check("t1_ready_low", cor_result_ready, 0);
    wait_we(n, rdy_seen);
    check("t1_we_latency", n, 6);
    check("t1_ready_busy", rdy_seen, 0);
    check("t1_wr_addr", addr, 0);
    for (int k = 0; k < FN; k++) begin
      check("t1_bin_i", get_i(d4wt, k), 100);
      check("t1_bin_q", get_q(d4wt, k), -50);
    end
    @(negedge clk);
    check("t1_max_exp", max_exp, 7);
    check("t1_ready_back", cor_result_ready, 1);
`ifdef COH_ACC_SAT_CNT_EN
    check("t1_sat_cnt", sat_count, 0);
`endif

    // twiddle rotation on bin1 (cos=0, sin=511), near-unity on the others
    w = '0;
    w[3*AW +: AW] = 24'd1000;
    poke(10'd0, w);
    send(512, 0, 1'b1, 1'b0, 1'b0);
    wait_we(n, rdy_seen);
    check("t2_bin1_i", get_i(d4wt, 1), 1000);
    check("t2_bin1_q", get_q(d4wt, 1), 511);
    check("t2_bin0_i", get_i(d4wt, 0), 511);
    check("t2_bin0_q", get_q(d4wt, 0), 0);
    @(negedge clk);
    check("t2_max_exp", max_exp, 10);

    // positive and negative saturation
    w = '0;
    w[1*AW +: AW] = 24'd8388000;
    w[4*AW +: AW] = -24'sd8388600;
    poke(10'd0, w);
    send(1000, -100, 1'b1, 1'b0, 1'b1);
    wait_we(n, rdy_seen);
    check("t3_bin0_i_sat", get_i(d4wt, 0), 8388607);
    check("t3_bin0_q", get_q(d4wt, 0), -100);
    check("t3_bin2_i", get_i(d4wt, 2), 1000);
    check("t3_bin2_q_sat", get_q(d4wt, 2), -8388608);
    check("t3_bin3_q", get_q(d4wt, 3), -100);
    @(negedge clk);
    check("t3_max_exp", max_exp, 23);
`ifdef COH_ACC_SAT_CNT_EN
    check("t3_sat_cnt", sat_count, 2);
`endif

    // full segment of 682 words
    for (int i = 0; i < 682; i++) begin
      send(i % 100, 0, (i == 0), 1'b1, 1'b1);
      if (i == 0) check("t4_first_rd_addr", addr, 0);
      wait_we(n, rdy_seen);
      if (i == 0) check("t4_first_wr_addr", addr, 0);
      if (i == 681) check("t4_last_wr_addr", addr, 681);
    end
    @(negedge clk);
    check("t4_write_finish", write_finish, 1);
    check("t4_read_finish", read_finish, 1);
    send(5, 5, 1'b0, 1'b1, 1'b1);
    check("t4_wrap_rd_addr", addr, 0);
    wait_we(n, rdy_seen);
    check("t4_wrap_wr_addr", addr, 0);

    // valid held high across back-to-back transactions
    @(negedge clk);
    acc_n = 0;
    wr_n = 0;
    last = 0;
    first_result = 1'b0;
    first_segment = 1'b1;
    first_acc = 1'b1;
    for (int c = 0; c < 60 && wr_n < 3; c++) begin
      if (we) begin
        check("t5_wr_i", get_i(d4wt, 0), seq_x[wr_n]);
        check("t5_wr_q", get_q(d4wt, 3), -seq_x[wr_n]);
        wr_n++;
      end
      if (cor_result_ready && acc_n < 3) begin
        if (acc_n > 0) check("t5_accept_gap", c - last, FN + 4);
        last = c;
        cor_result_valid = 1'b1;
        cor_result_i = 16'(seq_x[acc_n]);
        cor_result_q = 16'(-seq_x[acc_n]);
        acc_n++;
      end
      @(negedge clk);
    end
    cor_result_valid = 1'b0;
    check("t5_writes", wr_n, 3);
    check("t5_accepts", acc_n, 3);

    // reset in the middle of CALC
    send(500, 500, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("t6_ready", cor_result_ready, 1);
    check("t6_we", we, 0);
    check("t6_max_exp", max_exp, 0);
`ifdef COH_ACC_SAT_CNT_EN
    check("t6_sat_cnt", sat_count, 0);
`endif
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (we) bad = 1'b1;
    end
    check("t6_no_write", bad, 0);
    rst_b = 1'b1;
    send(7, 7, 1'b0, 1'b1, 1'b1);
    check("t6_rd_addr", addr, 0);
    wait_we(n, rdy_seen);
    check("t6_wr_addr", addr, 0);
    check("t6_bin_i", get_i(d4wt, 2), 7);
    @(negedge clk);
    check("t6_max_exp_after", max_exp, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
